frame_sync_ctrl: RTL and testbench

FRAME_SYNC_CTRL -- requirements
Module: frame_sync_ctrl

---
 rtl/frame_sync_pkg.sv | 25 ++
 rtl/seq_det_10011.sv | 36 +++
 rtl/frame_sync_ctrl.sv | 147 ++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// ----------------------------------------------------------------------------
// frame_sync_pkg
// Shared definitions for the frame synchroniser: framing state encoding, the
// sync word and its length, and a small saturating counter helper.
// No ports (package).
// ----------------------------------------------------------------------------
package frame_sync_pkg;

    // Framing state machine encoding
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } sync_state_t;

    // Sync word that closes every frame, first transmitted bit is the MSB
    localparam int                  SYNC_LEN     = 5;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 5'b10011;

    // 4-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/seq_det_10011.sv
// ----------------------------------------------------------------------------
// seq_det_10011
// Overlapping Mealy detector for the sync word 10011. hit is combinational
// and rises on the accepted bit that completes the pattern.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears the bit history
//   en     : the current in_bit is accepted (history advances only then)
//   in_bit : serial stream bit
//   hit    : last five accepted bits, including this one, equal 10011
// ----------------------------------------------------------------------------
module seq_det_10011
    import frame_sync_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_bit,
    output logic hit
);

    logic [SYNC_LEN-2:0] hist;

    // The pattern starts with a 1, so a cleared all-zero history can never
    // produce a false hit before enough real bits have arrived.
    assign hit = en && ({hist, in_bit} == SYNC_PATTERN);

    // Keep the last four accepted bits; idle cycles leave the history alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (en) begin
            hist <= {hist[SYNC_LEN-3:0], in_bit};
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// ----------------------------------------------------------------------------
// frame_sync_ctrl
// Frame synchroniser for a serial stream of frames made of PAYLOAD_LEN payload
// bits followed by the 5-bit sync word 10011. Hunts for the sync word,
// verifies it at frame-aligned checkpoints, and once locked forwards payload
// bits with one cycle of latency. Lock survives up to MISS_CNT-1 consecutive
// bad sync words (flywheel).
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   in_valid    : in_bit is accepted on this edge
//   in_bit      : serial stream bit
//   out_valid   : one-cycle pulse, out_bit holds a payload bit
//   out_bit     : registered payload bit
//   frame_start : coincident with out_valid for payload bit 0
//   locked      : high while in LOCKED
//   sync_err    : one-cycle pulse on a frame-aligned sync miss
// ----------------------------------------------------------------------------
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter int PAYLOAD_LEN = 8,
    parameter int LOCK_CNT    = 2,
    parameter int MISS_CNT    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit,
    output logic frame_start,
    output logic locked,
    output logic sync_err
);

    localparam int         FRAME_LEN = PAYLOAD_LEN + SYNC_LEN;
    localparam logic [7:0] LAST_POS  = 8'(FRAME_LEN - 1);
    localparam logic [7:0] PAY_END   = 8'(PAYLOAD_LEN);
    localparam logic [3:0] LOCK_LIM  = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_LIM  = 4'(MISS_CNT);

    sync_state_t state;
    logic [7:0]  pos;
    logic [3:0]  hit_cnt;
    logic [3:0]  miss_cnt;
    logic        hit;
    logic        checkpoint;
    logic [7:0]  pos_next;
    logic [3:0]  hit_inc;
    logic [3:0]  miss_inc;

    seq_det_10011 u_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_valid),
        .in_bit (in_bit),
        .hit    (hit)
    );

    // pos is the frame position of the bit being accepted now; the last sync
    // bit of a frame sits at the checkpoint, after which pos wraps to 0.
    assign checkpoint = (pos == LAST_POS);
    assign pos_next   = checkpoint ? 8'd0 : pos + 8'd1;
    assign hit_inc    = sat_inc4(hit_cnt);
    assign miss_inc   = sat_inc4(miss_cnt);

    // Framing FSM with registered outputs. Everything advances only on
    // accepted bits. Payload output is decided by the state the bit was
    // accepted in, so a bit already registered is still delivered when lock
    // is lost on a later checkpoint. A checkpoint miss that drops to HUNT
    // does not re-arm on that bit; the detector simply keeps it in history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            pos         <= 8'd0;
            hit_cnt     <= 4'd0;
            miss_cnt    <= 4'd0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (in_valid) begin
                if (state == LOCKED && pos < PAY_END) begin
                    out_valid   <= 1'b1;
                    out_bit     <= in_bit;
                    frame_start <= (pos == 8'd0);
                end
                case (state)
                    HUNT: begin
                        if (hit) begin
                            pos     <= 8'd0;
                            hit_cnt <= 4'd1;
                            if (LOCK_LIM == 4'd1) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
                            end else begin
                                state <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        pos <= pos_next;
                        if (checkpoint) begin
                            if (hit) begin
                                hit_cnt <= hit_inc;
                                if (hit_inc == LOCK_LIM) begin
                                    state    <= LOCKED;
                                    locked   <= 1'b1;
                                    miss_cnt <= 4'd0;
                                end
                            end else begin
                                state    <= HUNT;
                                sync_err <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        pos <= pos_next;
                        if (checkpoint) begin
                            if (hit) begin
                                miss_cnt <= 4'd0;
                            end else begin
                                sync_err <= 1'b1;
                                miss_cnt <= miss_inc;
                                if (miss_inc == MISS_LIM) begin
                                    state  <= HUNT;
                                    locked <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// ----------------------------------------------------------------------------
// tb_frame_sync_ctrl
// Directed self-checking bench for frame_sync_ctrl with PAYLOAD_LEN=8,
// LOCK_CNT=2, MISS_CNT=2. Each frame is sent as a 13-bit vector
// {payload, sync} MSB first; per accepted bit the outputs are captured into
// masks (bit i = i-th accepted bit of the sequence) and compared as one
// packed word {locked, sync_err, frame_start, out_valid, payload bits}.
// ----------------------------------------------------------------------------
module tb_frame_sync_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_bit;
    logic out_valid;
    logic out_bit;
    logic frame_start;
    logic locked;
    logic sync_err;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [12:0] vm;
    logic [12:0] fm;
    logic [12:0] em;
    logic [12:0] lm;
    logic [7:0]  bits;
    logic [59:0] obs;
    logic [59:0] exp_v;
    int          gap_bad;

    frame_sync_ctrl #(
        .PAYLOAD_LEN (8),
        .LOCK_CNT    (2),
        .MISS_CNT    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Drive one bit at the falling edge, then let the rising edge take it and
    // settle for 1 ns so the registered outputs for that bit are visible.
    task automatic applyStimulus(input logic b, input logic v);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    // Send n bits of vec MSB first and record what the DUT shows after each
    // accepted bit. With gap set, an idle cycle carrying the inverted bit
    // follows every accepted bit; any pulse during an idle cycle is counted.
    task automatic send_seq(input logic [12:0] vec, input int n, input bit gap);
        vm = '0; fm = '0; em = '0; lm = '0; bits = '0; gap_bad = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(vec[n-1-i], 1'b1);
            vm[i] = out_valid;
            fm[i] = frame_start;
            em[i] = sync_err;
            lm[i] = locked;
            if (out_valid) bits = {bits[6:0], out_bit};
            if (gap) begin
                applyStimulus(~vec[n-1-i], 1'b0);
                if (out_valid || frame_start || sync_err) gap_bad++;
            end
        end
        obs = {lm, em, fm, vm, bits};
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cnt++;
        if ({out_valid, out_bit, frame_start, locked, sync_err} !== 5'b0)
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {out_valid, out_bit, frame_start, locked, sync_err});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock_acquire();
        send_seq(13'b10011, 5, 1'b0);
        check_cnt++;
        if (obs !== 60'h0) $display("[TB] FAIL hunt_hit: got %h expected %h", obs, 60'h0);
        else pass_cnt++;

        send_seq({8'hA5, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1000, 13'h0000, 13'h0000, 13'h0000, 8'h00};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL verify_to_lock: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        send_seq({8'hA5, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h0000, 13'h0001, 13'h00FF, 8'hA5};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL first_payload_a5: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        send_seq({8'h3C, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h0000, 13'h0001, 13'h00FF, 8'h3C};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL payload_3c: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_flywheel();
        send_seq({8'h5A, 5'b10010}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h1000, 13'h0001, 13'h00FF, 8'h5A};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL flywheel_miss: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        send_seq({8'hC3, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h0000, 13'h0001, 13'h00FF, 8'hC3};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL flywheel_recover: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        // miss_cnt was cleared, so a single further miss must keep lock
        send_seq({8'hA5, 5'b10010}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h1000, 13'h0001, 13'h00FF, 8'hA5};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL miss_cnt_cleared: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        send_seq({8'h3C, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h0000, 13'h0001, 13'h00FF, 8'h3C};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL flywheel_good2: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_lose_lock();
        send_seq({8'hA5, 5'b10010}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h1000, 13'h0001, 13'h00FF, 8'hA5};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL lose_first_miss: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        // locked falls after the checkpoint; payload already sent still shows
        send_seq({8'h96, 5'b10010}, 13, 1'b0);
        exp_v = {13'h0FFF, 13'h1000, 13'h0001, 13'h00FF, 8'h96};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL lose_second_miss: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        // back in HUNT: no payload, sync word at the end re-arms into VERIFY
        send_seq({8'hA5, 5'b10011}, 13, 1'b0);
        check_cnt++;
        if (obs !== 60'h0) $display("[TB] FAIL hunt_no_output: got %h expected %h", obs, 60'h0);
        else pass_cnt++;
    endtask

    task automatic test_verify_false_hit();
        // payload 00100110 holds 10011 at bits 2..6, bad sync at the checkpoint
        send_seq({8'h26, 5'b10010}, 13, 1'b0);
        exp_v = {13'h0000, 13'h1000, 13'h0000, 13'h0000, 8'h00};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL verify_false_hit: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        send_seq({8'hA5, 5'b10011}, 13, 1'b0);
        check_cnt++;
        if (obs !== 60'h0) $display("[TB] FAIL hunt_after_verify: got %h expected %h", obs, 60'h0);
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        // DUT is in VERIFY with one hit; the idle cycles carry inverted bits
        send_seq({8'hA5, 5'b10011}, 13, 1'b1);
        exp_v = {13'h1000, 13'h0000, 13'h0000, 13'h0000, 8'h00};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL gapped_lock: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        check_cnt++;
        if (gap_bad !== 0) $display("[TB] FAIL gapped_idle1: got %0d expected 0", gap_bad);
        else pass_cnt++;

        send_seq({8'hA5, 5'b10011}, 13, 1'b1);
        exp_v = {13'h1FFF, 13'h0000, 13'h0001, 13'h00FF, 8'hA5};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL gapped_payload: got %h expected %h", obs, exp_v);
        else pass_cnt++;
        check_cnt++;
        if (gap_bad !== 0) $display("[TB] FAIL gapped_idle2: got %0d expected 0", gap_bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // first three payload bits of A5 while locked
        send_seq(13'b101, 3, 1'b0);
        check_cnt++;
        if ({locked, out_valid, out_bit} !== 3'b111)
            $display("[TB] FAIL mid_pre_reset: got %b expected 111", {locked, out_valid, out_bit});
        else pass_cnt++;

        // assert reset between edges; outputs must clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({out_valid, out_bit, frame_start, locked, sync_err} !== 5'b0)
            $display("[TB] FAIL mid_async_reset: got %b expected 00000",
                     {out_valid, out_bit, frame_start, locked, sync_err});
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // remainder of the interrupted frame: detector restarted, hit at end
        send_seq({5'b00101, 5'b10011}, 10, 1'b0);
        check_cnt++;
        if (obs !== 60'h0) $display("[TB] FAIL mid_rest_hunt: got %h expected %h", obs, 60'h0);
        else pass_cnt++;

        send_seq({8'h5A, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1000, 13'h0000, 13'h0000, 13'h0000, 8'h00};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL mid_relock: got %h expected %h", obs, exp_v);
        else pass_cnt++;

        send_seq({8'hC3, 5'b10011}, 13, 1'b0);
        exp_v = {13'h1FFF, 13'h0000, 13'h0001, 13'h00FF, 8'hC3};
        check_cnt++;
        if (obs !== exp_v) $display("[TB] FAIL mid_relock_payload: got %h expected %h", obs, exp_v);
        else pass_cnt++;
    endtask

    // Main sequence: one continuous stream, each test starts from the state
    // the previous one left behind.
    initial begin
        test_reset();
        test_lock_acquire();
        test_flywheel();
        test_lose_lock();
        test_verify_false_hit();
        test_gapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of test, required finish before 200000 ns");
        $fatal(1, "[TB] timeout");
    end

endmodule
